insert_sort4_loader: RTL and testbench

//  Front-end stage that feeds the 4-to-8 registered odd-even merger.

---
 rtl/insert_sort4_loader.sv | 141 ++++++++++++++
 tb/tb_insert_sort4_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/insert_sort4_loader.sv
// Insertion-sort loader: collects groups of N keys from a valid/ready stream,
// keeps each group sorted ascending while it fills, and presents the sorted
// group on one half of inba (A, then B) with a one-cycle load strobe.
module insert_sort4_loader #(
  parameter int WIDTH = 3,
  parameter int N     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [1:0]             load,
  output logic [2*N*WIDTH-1:0]   inba,
  output logic                   frame_done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {S_FILL, S_PUSH} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   half_q, half_d;
  logic [WIDTH-1:0]       buf_q [N];
  logic [WIDTH-1:0]       buf_d [N];
  logic [2*N*WIDTH-1:0]   inba_q, inba_d;
  logic [1:0]             load_q, load_d;
  logic                   frame_done_q, frame_done_d;

  logic                   accept;
  logic                   close_group;
  logic [CW-1:0]          fill_count;
  logic [N-1:0]           le;
  logic [WIDTH-1:0]       ins_buf  [N];
  logic [WIDTH-1:0]       fill_buf [N];
  logic [N*WIDTH-1:0]     push_slots;

  // Ready only while filling and never while reset is held.
  assign in_ready = rst & (state_q == S_FILL);
  assign accept   = in_valid & in_ready;

  assign fill_count = count_q + CW'(accept);

  // A group closes when it becomes full, or on flush if there is something to
  // push (any key, or the B half which must still complete the frame).
  assign close_group = (state_q == S_FILL) &&
                       ((fill_count == CW'(N)) ||
                        (flush && ((fill_count != '0) || half_q)));

  // Per-slot insertion network. le[gi] marks occupied slots holding a key
  // <= the new one; because the buffer is sorted this is a prefix, so the new
  // key lands just after the last such slot and later entries shift up.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      assign le[gi] = (CW'(gi) < count_q) && (buf_q[gi] <= in_data);
      if (gi == 0) begin : g_first
        assign ins_buf[gi] = le[gi] ? buf_q[gi] : in_data;
      end else begin : g_rest
        assign ins_buf[gi] = le[gi]     ? buf_q[gi] :
                             le[gi-1]   ? in_data   : buf_q[gi-1];
      end
      assign fill_buf[gi] = accept ? ins_buf[gi] : buf_q[gi];
      // Unfilled slots are padded with the maximum key when pushed.
      assign push_slots[gi*WIDTH +: WIDTH] =
        (CW'(gi) < fill_count) ? fill_buf[gi] : {WIDTH{1'b1}};
    end
  endgenerate

  // Next-state logic: fill/insert, latch the sorted group into its half of
  // inba when the group closes, then clear and switch halves.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    half_d       = half_q;
    buf_d        = buf_q;
    inba_d       = inba_q;
    load_d       = 2'b00;
    frame_done_d = 1'b0;
    case (state_q)
      S_FILL: begin
        buf_d   = fill_buf;
        count_d = fill_count;
        if (close_group) begin
          state_d = S_PUSH;
          if (half_q) begin
            inba_d[2*N*WIDTH-1:N*WIDTH] = push_slots;
            load_d       = 2'b10;
            frame_done_d = 1'b1;
          end else begin
            inba_d[N*WIDTH-1:0] = push_slots;
            load_d = 2'b01;
          end
        end
      end
      S_PUSH: begin
        state_d = S_FILL;
        count_d = '0;
        half_d  = ~half_q;
        for (int i = 0; i < N; i++) begin
          buf_d[i] = '0;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FILL;
      count_q      <= '0;
      half_q       <= 1'b0;
      inba_q       <= '0;
      load_q       <= 2'b00;
      frame_done_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      half_q       <= half_d;
      inba_q       <= inba_d;
      load_q       <= load_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign load       = load_q;
  assign inba       = inba_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_insert_sort4_loader.sv
// Scoreboard bench for insert_sort4_loader: a group-level model predicts each
// push; a monitor compares every load cycle and the idle-hold behaviour.
module tb_insert_sort4_loader;

  localparam int W = 3;
  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic [W-1:0]       in_data = '0;
  logic               flush = 1'b0;
  logic               in_ready;
  logic [1:0]         load;
  logic [2*N*W-1:0]   inba;
  logic               frame_done;

  insert_sort4_loader #(.WIDTH(W), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .load       (load),
    .inba       (inba),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       load;
    logic [2*N*W-1:0] inba;
    logic             fd;
    time              t;
  } exp_t;

  exp_t             sb[$];
  int               errors = 0;
  int               checks = 0;

  int               mkeys[$];
  logic             mhalf = 1'b0;
  logic             exp_ready = 1'b0;
  logic [2*N*W-1:0] minba = '0;
  logic             in_rst = 1'b1;
  logic [2*N*W-1:0] mon_inba = '0;
  exp_t             me;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Group model: sort the collected keys by value, pad with all-ones and
  // write them into the current half of the running inba image.
  task automatic close_group();
    int   sorted[$];
    exp_t e;
    for (int v = 0; v < (1 << W); v++)
      foreach (mkeys[j])
        if (mkeys[j] == v) sorted.push_back(v);
    e.inba = minba;
    for (int k = 0; k < N; k++)
      e.inba[(int'(mhalf) * N + k) * W +: W] = (k < sorted.size()) ? W'(sorted[k]) : {W{1'b1}};
    e.load = mhalf ? 2'b10 : 2'b01;
    e.fd   = mhalf;
    e.t    = $time;
    minba  = e.inba;
    sb.push_back(e);
    $display("push half=%0d inba=%o", mhalf, e.inba);
    mkeys.delete();
    mhalf     = ~mhalf;
    exp_ready = 1'b0;
  endtask

  task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic f, output logic acc);
    @(negedge clk);
    check("in_ready", in_ready, exp_ready);
    in_valid = v;
    in_data  = d;
    flush    = f;
    acc      = 1'b0;
    if (exp_ready) begin
      if (v) begin
        mkeys.push_back(int'(d));
        acc = 1'b1;
        $display("accept key=%0d flush=%0d count=%0d", d, f, mkeys.size());
      end
      if (mkeys.size() == N || (f && (mkeys.size() > 0 || mhalf))) close_group();
    end else begin
      exp_ready = 1'b1;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    in_rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    mkeys.delete();
    sb.delete();
    mhalf = 1'b0;
    minba = '0;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_load", load, 0);
      check("rst_inba", inba, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_in_ready", in_ready, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    in_rst = 1'b0;
    exp_ready = 1'b1;
  endtask

  // Monitor: pop and compare on every load; between loads, outputs must hold.
  always @(posedge clk) begin
    #1;
    if (in_rst) begin
      mon_inba = '0;
    end else begin
      check("load_not_11", (load == 2'b11), 0);
      if (load != 2'b00) begin
        if (sb.size() == 0) begin
          check("unexpected_load", load, 0);
        end else begin
          me = sb.pop_front();
          check("load", load, me.load);
          check("inba", inba, me.inba);
          check("frame_done", frame_done, me.fd);
          mon_inba = me.inba;
        end
      end else begin
        check("frame_done_idle", frame_done, 0);
        check("inba_hold", inba, mon_inba);
        if (sb.size() > 0 && ($time - sb[0].t) > 12) begin
          me = sb.pop_front();
          check("missing_load", load, me.load);
          mon_inba = me.inba;
        end
      end
    end
  end

  logic       acc;
  logic       rv;
  logic [2:0] rd;
  logic       rf;

  initial begin
    do_reset(2);

    // Group A: 5,2,7,2
    drive_cycle(1, 5, 0, acc); drive_cycle(1, 2, 0, acc);
    drive_cycle(1, 7, 0, acc); drive_cycle(1, 2, 0, acc);
    @(posedge clk); #2;
    check("t1_load", load, 2'b01);
    check("t1_a", inba[11:0], 12'o7522);

    // Group B: 6,0,3,1
    drive_cycle(0, 0, 0, acc);
    drive_cycle(1, 6, 0, acc); drive_cycle(1, 0, 0, acc);
    drive_cycle(1, 3, 0, acc); drive_cycle(1, 1, 0, acc);
    @(posedge clk); #2;
    check("t2_load", load, 2'b10);
    check("t2_fd", frame_done, 1);
    check("t2_inba", inba, 24'o63107522);

    // Partial A via flush
    drive_cycle(0, 0, 0, acc);
    drive_cycle(1, 3, 0, acc); drive_cycle(1, 1, 0, acc);
    drive_cycle(0, 0, 1, acc);
    @(posedge clk); #2;
    check("t3_a", inba[11:0], 12'o7731);

    // Empty B flushed to all-ones
    drive_cycle(0, 0, 0, acc);
    drive_cycle(0, 0, 1, acc);
    @(posedge clk); #2;
    check("t4_load", load, 2'b10);
    check("t4_b", inba[23:12], 12'o7777);
    check("t4_fd", frame_done, 1);

    // Flush with empty A group must be ignored
    drive_cycle(0, 0, 0, acc);
    drive_cycle(0, 0, 1, acc);
    drive_cycle(0, 0, 0, acc);

    // Key held through the PUSH cycle is taken exactly once
    drive_cycle(1, 5, 0, acc); drive_cycle(1, 2, 0, acc);
    drive_cycle(1, 7, 0, acc); drive_cycle(1, 2, 0, acc);
    drive_cycle(1, 4, 0, acc);
    drive_cycle(1, 4, 0, acc);
    drive_cycle(1, 1, 0, acc); drive_cycle(1, 1, 0, acc);
    drive_cycle(1, 1, 0, acc);
    @(posedge clk); #2;
    check("t5_b", inba[23:12], 12'o4111);

    // Reset mid-group
    drive_cycle(0, 0, 0, acc);
    drive_cycle(1, 1, 0, acc); drive_cycle(1, 2, 0, acc);
    do_reset(2);
    drive_cycle(1, 1, 0, acc); drive_cycle(1, 1, 0, acc);
    drive_cycle(1, 0, 0, acc); drive_cycle(1, 2, 0, acc);
    @(posedge clk); #2;
    check("t6_load", load, 2'b01);
    check("t6_inba", inba, 24'o00002110);

    // Randomized traffic with source-side hold and occasional flush/reset
    rv = 1'b0; rd = '0; acc = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        do_reset(1);
        rv = 1'b0; acc = 1'b1;
      end
      if (!(rv && !acc)) begin
        rv = ($urandom_range(0, 3) != 0);
        rd = 3'($urandom_range(0, 7));
      end
      rf = ($urandom_range(0, 9) == 0);
      drive_cycle(rv, rd, rf, acc);
    end

    repeat (4) drive_cycle(0, 0, 0, acc);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
